registro_tx_serial: RTL and testbench
=====================================

// Module: registro_tx_serial
// PURPOSE
//   Reader/transmitter end of the 12-bit product-code register.
//   Captures the register's parallel output word (price / expiry code) on a
//   start request and sends it out one bit at a time on a single line.
//   Frame: start bit, data MSB-first, even parity bit, stop bit.
//   Sits directly after the transparent D register and drives the serial
//   link to the display/checkout unit.
// PARAMETERS
//   WIDTH  12  data word width in bits, matching the register bus
//   DIV    4   clock cycles per serial bit, must be >= 1
// PORTS
//   clk   in   1      system clock, rising-edge active
//   clr   in   1      asynchronous active-low reset
//   en    in   1      start request, sampled only in IDLE
//   D     in   WIDTH  parallel word from register output Q
//   tx    out  1      serial line, idles high
//   busy  out  1      high while a frame is in progress
//   done  out  1      one-cycle pulse when a frame completes
// BEHAVIOUR
// - Reset (clr=0, async): tx=1, busy=0, done=0, state=IDLE.
//   Shift register, parity, bit counter and DIV counter are cleared.
// - All outputs are registered.
// - States:
//   - IDLE -> START when en=1 at a clock edge.
//   - START -> DATA -> PARITY -> STOP -> IDLE.
//   - Each state holds for exactly DIV cycles.
//   - DATA holds for WIDTH*DIV cycles in total.
// - Capture edge (edge 0, IDLE with en=1):
//   - D is latched into the shift register.
//   - Parity = ^D (even parity: total ones in data plus parity is even).
//   - busy goes to 1 and tx goes to 0 (start bit).
// - Later changes on D are ignored until the next capture.
// - Data bit i (i=0 is the MSB) drives tx during cycles (1+i)*DIV .. (2+i)*DIV-1.
// - PARITY drives tx=parity during cycles (WIDTH+1)*DIV .. (WIDTH+2)*DIV-1.
// - STOP drives tx=1 during cycles (WIDTH+2)*DIV .. (WIDTH+3)*DIV-1.
// - At edge (WIDTH+3)*DIV: state=IDLE, busy=0, done=1 for one cycle, tx stays 1.
// - Frame length is (WIDTH+3)*DIV cycles; with the defaults that is 60.
// - en while busy=1 is ignored; there is no queueing.
// - en=1 on the edge that returns to IDLE is also ignored.
// - Earliest next capture is the edge after done; back-to-back frames
//   therefore have a 1-cycle idle gap with tx=1.
// - en held high continuously gives a new frame after every gap.
// - Reset mid-frame aborts immediately: tx=1, busy=0, and no done pulse.
// - Counters never wrap. The bit counter runs 0..WIDTH-1 and the DIV counter
//   runs 0..DIV-1; both reload at each state change.
// - DIV=1 is legal: one bit per clock, no idle cycles inside a frame.
// TESTING
//   T1 Reset: clr=0 mid-cycle -> tx=1, busy=0, done=0 asynchronously;
//      en=1 with clr=0 -> no frame.
//   T2 D=12'b000011000100, en pulse (DIV=4) -> tx sequence
//      0, 000011000100, parity 1, stop 1; each bit 4 cycles;
//      done exactly 60 cycles after capture.
//   T3 D=12'hFFF -> parity 0;
//      D changed to 12'b110100010001 at cycle 10 -> transmitted data is still FFF.
//   T4 en held high, D=12'b011110010101 -> frames repeat with parity 1;
//      exactly 1 idle cycle (tx=1, busy=0) between done and the next start bit.
//   T5 clr=0 at cycle 25 of a frame -> tx=1 at once, no done pulse;
//      after release, en -> a clean full frame.
//   T6 en pulses at cycles 5 and 59 of a frame -> ignored;
//      only one done pulse is produced.

Source files
------------

// File: rtl/registro_tx_serial.sv
// Serial transmitter for the 12-bit product-code register.
// Frame: start bit, data MSB-first, even parity, stop bit; each bit lasts DIV clocks.
module registro_tx_serial #(
    parameter int WIDTH = 12,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_par;
    logic [BIT_W-1:0]   r_bit;
    logic [DIV_W-1:0]   r_div;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;

    logic               w_div_end;
    logic               w_bit_end;

    assign w_div_end = (r_div == DIV_W'(DIV - 1));
    assign w_bit_end = (r_bit == BIT_W'(WIDTH - 1));

    // tx always carries the bit of the current state; the next bit is loaded
    // on the same edge that ends the current one, so tx never lags a cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_bit   <= '0;
            r_div   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= START;
                        r_shreg <= D;
                        r_par   <= ^D;
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_div_end) begin
                        r_state <= DATA;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shreg[WIDTH-1];
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (w_bit_end) begin
                            r_state <= PARITY;
                            r_bit   <= '0;
                            r_tx    <= r_par;
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_tx    <= r_shreg[WIDTH-2];
                            r_shreg <= r_shreg << 1;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                PARITY: begin
                    if (w_div_end) begin
                        r_state <= STOP;
                        r_div   <= '0;
                        r_tx    <= 1'b1;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (w_div_end) begin
                        r_state <= IDLE;
                        r_div   <= '0;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_registro_tx_serial.sv
// Directed bench for registro_tx_serial with WIDTH=12, DIV=4 (60-cycle frames).
module tb_registro_tx_serial;

    logic        clk;
    logic        clr;
    logic        en;
    logic [11:0] D;
    logic        tx;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    registro_tx_serial #(.WIDTH(12), .DIV(4)) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .D    (D),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts from a negedge in IDLE, captures d at the next posedge (edge 0) and
    // walks cycles 0..60 at negedges. Cycle k uses frame slot k/4:
    // 0 start, 1..12 data MSB-first, 13 parity, 14 stop.
    task automatic frame(input logic [11:0] d, input logic par, input logic hold_en,
                         input int chg_cyc, input logic [11:0] d_new,
                         input int en_a, input int en_b, input string nm);
        logic exp_tx;
        int   slot;
        D  = d;
        en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 60; k++) begin
            en = (k == en_a || k == en_b) ? 1'b1 : hold_en;
            if (k == chg_cyc) D = d_new;
            slot = k / 4;
            if (slot == 0)       exp_tx = 1'b0;
            else if (slot <= 12) exp_tx = d[12 - slot];
            else if (slot == 13) exp_tx = par;
            else                 exp_tx = 1'b1;
            tests++;
            if (tx !== exp_tx || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s cyc%0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                         nm, k, tx, busy, done, exp_tx);
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL %s end: done=%b busy=%b tx=%b, required done=1 busy=0 tx=1",
                     nm, done, busy, tx);
        end
        en = hold_en;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        en  = 1'b1;
        D   = 12'hA5A;
        #2;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: tx=%b busy=%b done=%b, required 1/0/0", tx, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold_en cyc%0d: tx=%b busy=%b done=%b, required 1/0/0",
                         i, tx, busy, done);
            end
        end
        en  = 1'b0;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: tx=%b busy=%b, required 1/0", tx, busy);
        end
    endtask

    task automatic test_basic_frame();
        frame(12'b000011000100, 1'b1, 1'b0, -1, 12'h000, -1, -1, "t2_frame");
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL t2_done_pulse: done=%b busy=%b tx=%b, required 0/0/1", done, busy, tx);
        end
    endtask

    task automatic test_d_ignored();
        frame(12'hFFF, 1'b0, 1'b0, 10, 12'b110100010001, -1, -1, "t3_fff_dchg");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        // Cycle 60 of each frame is the single idle gap (checked at frame end).
        frame(12'b011110010101, 1'b1, 1'b1, -1, 12'h000, -1, -1, "t4_frame0");
        frame(12'b011110010101, 1'b1, 1'b1, -1, 12'h000, -1, -1, "t4_frame1");
        frame(12'b011110010101, 1'b1, 1'b0, -1, 12'h000, -1, -1, "t4_frame2");
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL t4_stop_after_en_low: busy=%b tx=%b, required 0/1", busy, tx);
        end
    endtask

    task automatic test_reset_abort();
        int done_seen;
        D  = 12'b101010101010;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (25) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL t5_busy_before_abort: busy=%b, required 1", busy);
        end
        #2 clr = 1'b0;
        #1;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL t5_abort_async: tx=%b busy=%b done=%b, required 1/0/0", tx, busy, done);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) clr = 1'b1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL t5_no_done_after_abort: activity cycles=%0d, required 0", done_seen);
        end
        frame(12'b001100111100, 1'b0, 1'b0, -1, 12'h000, -1, -1, "t5_clean_frame");
        @(negedge clk);
    endtask

    task automatic test_en_while_busy();
        int dones;
        frame(12'b100000000001, 1'b0, 1'b0, -1, 12'h000, 5, 59, "t6_frame");
        dones = 1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            tests++;
            if (busy !== 1'b0 || tx !== 1'b1) begin
                fails++;
                $display("FAIL t6_idle_after cyc%0d: busy=%b tx=%b, required 0/1", i, busy, tx);
            end
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("FAIL t6_single_done: done pulses=%0d, required 1", dones);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clr   = 1'b0;
        en    = 1'b0;
        D     = '0;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_d_ignored();
        test_back_to_back();
        test_reset_abort();
        test_en_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
